// File: rtl/serial_audio_decoder_pkg.sv
// Shared types and constants for the serial audio decoder.
package serial_audio_decoder_pkg;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_SKIP,
    ST_SHIFT,
    ST_DONE
  } state_e;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/serial_audio_word_buffer.sv
// Output holding register with valid/ready handshake and sticky overrun flag.
module serial_audio_word_buffer
  import serial_audio_decoder_pkg::*;
#(
  parameter int audio_width = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_i,
  input  logic [audio_width-1:0] data_i,
  input  logic                   is_left_i,
  input  logic                   ready_i,
  output logic                   valid_o,
  output logic                   is_left_o,
  output logic [audio_width-1:0] data_o,
  output logic                   overrun_o
);

  logic                   valid_q, valid_d;
  logic                   left_q, left_d;
  logic [audio_width-1:0] data_q, data_d;
  logic                   ovr_q, ovr_d;
  logic                   xfer, accept;

  always_comb begin
    xfer    = valid_q & ready_i;
    // A completing word may replace the held one only if that one leaves now.
    accept  = load_i & (~valid_q | ready_i);
    valid_d = valid_q;
    left_d  = left_q;
    data_d  = data_q;
    ovr_d   = ovr_q;
    if (accept) begin
      valid_d = 1'b1;
      left_d  = is_left_i;
      data_d  = data_i;
    end else if (xfer) begin
      valid_d = 1'b0;
    end
    if (load_i && !accept) ovr_d = 1'b1;
    else if (xfer)         ovr_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      left_q  <= 1'b0;
      data_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      left_q  <= left_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
    end
  end

  assign valid_o   = valid_q;
  assign is_left_o = left_q;
  assign data_o    = data_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/serial_audio_decoder.sv
// I2S / left-justified serial audio receiver: frames sdi by lrclk into words.
module serial_audio_decoder
  import serial_audio_decoder_pkg::*;
#(
  parameter int audio_width = 16
) (
  input  logic                   reset,
  input  logic                   clk,
  input  logic                   is_i2s,
  input  logic                   lrclk_polarity,
  input  logic                   lrclk,
  input  logic                   sdi,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic                   o_is_left,
  output logic [audio_width-1:0] o_audio,
  output logic                   is_overrun,
  output logic                   frame_error
);

  localparam int             CW   = $clog2(audio_width + 1);
  localparam logic [CW-1:0]  LAST = CW'(audio_width - 1);

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [audio_width-1:0] sh_q, sh_d;
  logic                   ch_q, chan_q, chan_d;
  logic                   ferr_q, ferr_d;
  logic                   ch, slot_start, restart, load;
  logic [audio_width-1:0] word;

  assign ch         = lrclk ^ lrclk_polarity;
  assign slot_start = ch != ch_q;
  assign word       = {sh_q[audio_width-2:0], sdi};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    chan_d  = chan_q;
    ferr_d  = 1'b0;
    restart = 1'b0;
    load    = 1'b0;
    case (state_q)
      ST_SYNC, ST_DONE: restart = slot_start;
      ST_SKIP: begin
        if (slot_start) begin
          restart = 1'b1;
        end else begin
          // The slot-start edge was the skipped one; this edge carries the MSB.
          sh_d    = {{(audio_width-1){1'b0}}, sdi};
          cnt_d   = CW'(1);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (slot_start) begin
          // In I2S the LSB of the old word rides on the new slot's first edge.
          if (is_i2s && cnt_q == LAST) load   = 1'b1;
          else                         ferr_d = 1'b1;
          restart = 1'b1;
        end else begin
          sh_d  = word;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            load    = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_SYNC;
    endcase
    if (restart) begin
      chan_d = ch;
      if (is_i2s) begin
        state_d = ST_SKIP;
        cnt_d   = '0;
      end else begin
        state_d = ST_SHIFT;
        cnt_d   = CW'(1);
        sh_d    = {{(audio_width-1){1'b0}}, sdi};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_SYNC;
      cnt_q   <= '0;
      sh_q    <= '0;
      ch_q    <= CH_RIGHT;
      chan_q  <= CH_RIGHT;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      ch_q    <= ch;
      chan_q  <= chan_d;
      ferr_q  <= ferr_d;
    end
  end

  assign frame_error = ferr_q;

  serial_audio_word_buffer #(.audio_width(audio_width)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .load_i    (load),
    .data_i    (word),
    .is_left_i (chan_q == CH_LEFT),
    .ready_i   (o_ready),
    .valid_o   (o_valid),
    .is_left_o (o_is_left),
    .data_o    (o_audio),
    .overrun_o (is_overrun)
  );

endmodule

// File: tb/tb_serial_audio_decoder.sv
// Directed bench for serial_audio_decoder (16-bit words, LJ and I2S framing).
module tb_serial_audio_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        is_i2s = 1'b0;
  logic        lrclk_polarity = 1'b0;
  logic        lrclk = 1'b1;
  logic        sdi = 1'b0;
  logic        o_valid;
  logic        o_ready = 1'b1;
  logic        o_is_left;
  logic [15:0] o_audio;
  logic        is_overrun;
  logic        frame_error;

  int          n_chk = 0;
  int          n_fail = 0;
  int          fe_cnt = 0;
  logic        rdy_nx = 1'b1;
  logic [16:0] xq[$];

  serial_audio_decoder #(.audio_width(16)) dut (
    .reset          (reset),
    .clk            (clk),
    .is_i2s         (is_i2s),
    .lrclk_polarity (lrclk_polarity),
    .lrclk          (lrclk),
    .sdi            (sdi),
    .o_valid        (o_valid),
    .o_ready        (o_ready),
    .o_is_left      (o_is_left),
    .o_audio        (o_audio),
    .is_overrun     (is_overrun),
    .frame_error    (frame_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bit time: inputs change on the falling edge; a transfer is logged when
  // valid&ready is seen just before the rising edge that completes it.
  task automatic tick(input logic lr, input logic d);
    @(negedge clk);
    if (frame_error) fe_cnt++;
    lrclk   = lr;
    sdi     = d;
    o_ready = rdy_nx;
    #1;
    if (o_valid && o_ready) xq.push_back({o_is_left, o_audio});
  endtask

  task automatic send_slot(input logic lr, input logic [15:0] w, input int len,
                           input logic i2s, input logic first);
    for (int i = 0; i < len; i++) begin
      int   k;
      logic d;
      k = i2s ? i - 1 : i;
      if (i2s && i == 0)      d = first;
      else if (k < 16)        d = w[15-k];
      else                    d = 1'b0;
      tick(lr, d);
    end
  endtask

  task automatic do_reset(input logic i2s, input logic pol, input logic lr);
    reset = 1'b1;
    is_i2s = i2s;
    lrclk_polarity = pol;
    lrclk = lr;
    sdi = 1'b0;
    rdy_nx = 1'b1;
    o_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    xq.delete();
    fe_cnt = 0;
  endtask

  task automatic chk_xq(input string tag, input int idx, input logic lf, input logic [15:0] d);
    if (idx < xq.size()) chk(tag, {15'd0, xq[idx]}, {15'd0, lf, d});
  endtask

  initial begin
    // Reset state
    do_reset(1'b0, 1'b0, 1'b1);
    #1;
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_audio", {16'd0, o_audio}, 32'd0);
    chk("rst_left",  {31'd0, o_is_left}, 32'd0);
    chk("rst_ovr",   {31'd0, is_overrun}, 32'd0);
    chk("rst_ferr",  {31'd0, frame_error}, 32'd0);

    // Left-justified, left then right
    repeat (3) tick(1'b1, 1'b0);
    send_slot(1'b0, 16'hA5C3, 16, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("lj_latency_valid", {31'd0, o_valid}, 32'd1);
    chk("lj_latency_data", {16'd0, o_audio}, 32'h0000A5C3);
    send_slot(1'b1, 16'h1234, 16, 1'b0, 1'b0);
    repeat (3) tick(1'b1, 1'b0);
    chk("lj_nxfer", xq.size(), 32'd2);
    chk_xq("lj_x0", 0, 1'b1, 16'hA5C3);
    chk_xq("lj_x1", 1, 1'b0, 16'h1234);
    chk("lj_ferr", fe_cnt, 32'd0);

    // I2S, 24-bit slots
    do_reset(1'b1, 1'b0, 1'b1);
    repeat (3) tick(1'b1, 1'b0);
    send_slot(1'b0, 16'hA5C3, 24, 1'b1, 1'b0);
    send_slot(1'b1, 16'h1234, 24, 1'b1, 1'b0);
    repeat (3) tick(1'b1, 1'b0);
    chk("i2s_nxfer", xq.size(), 32'd2);
    chk_xq("i2s_x0", 0, 1'b1, 16'hA5C3);
    chk_xq("i2s_x1", 1, 1'b0, 16'h1234);
    chk("i2s_ferr", fe_cnt, 32'd0);

    // I2S, 16-bit slots: each LSB lands on the next slot-start edge
    do_reset(1'b1, 1'b0, 1'b1);
    repeat (2) tick(1'b1, 1'b0);
    send_slot(1'b0, 16'hBEEF, 16, 1'b1, 1'b0);
    send_slot(1'b1, 16'h0F0F, 16, 1'b1, 1'b1);
    tick(1'b0, 1'b1);
    repeat (2) tick(1'b0, 1'b0);
    chk("i2s16_nxfer", xq.size(), 32'd2);
    chk_xq("i2s16_x0", 0, 1'b1, 16'hBEEF);
    chk_xq("i2s16_x1", 1, 1'b0, 16'h0F0F);
    chk("i2s16_ferr", fe_cnt, 32'd0);

    // Overrun with consumer stalled
    do_reset(1'b0, 1'b0, 1'b1);
    rdy_nx = 1'b0;
    repeat (2) tick(1'b1, 1'b0);
    send_slot(1'b0, 16'h1111, 16, 1'b0, 1'b0);
    send_slot(1'b1, 16'h2222, 16, 1'b0, 1'b0);
    send_slot(1'b0, 16'h3333, 16, 1'b0, 1'b0);
    repeat (2) tick(1'b0, 1'b0);
    chk("ovr_valid", {31'd0, o_valid}, 32'd1);
    chk("ovr_audio", {16'd0, o_audio}, 32'h00001111);
    chk("ovr_left", {31'd0, o_is_left}, 32'd1);
    chk("ovr_flag", {31'd0, is_overrun}, 32'd1);
    rdy_nx = 1'b1;
    tick(1'b0, 1'b0);
    @(posedge clk); #1;
    chk("ovr_nxfer", xq.size(), 32'd1);
    chk_xq("ovr_x0", 0, 1'b1, 16'h1111);
    chk("ovr_clr_valid", {31'd0, o_valid}, 32'd0);
    chk("ovr_clr_flag", {31'd0, is_overrun}, 32'd0);

    // Short slot then full left slot; then constant lrclk
    do_reset(1'b0, 1'b0, 1'b1);
    repeat (2) tick(1'b1, 1'b0);
    send_slot(1'b0, 16'h0F0F, 16, 1'b0, 1'b0);
    send_slot(1'b1, 16'hFFFF, 10, 1'b0, 1'b0);
    send_slot(1'b0, 16'h8001, 16, 1'b0, 1'b0);
    repeat (2) tick(1'b0, 1'b0);
    chk("fe_count", fe_cnt, 32'd1);
    chk("fe_nxfer", xq.size(), 32'd2);
    chk_xq("fe_x0", 0, 1'b1, 16'h0F0F);
    chk_xq("fe_x1", 1, 1'b1, 16'h8001);
    repeat (40) tick(1'b0, 1'b1);
    chk("const_lr_nxfer", xq.size(), 32'd2);
    chk("const_lr_ferr", fe_cnt, 32'd1);

    // Reset in the middle of a word
    do_reset(1'b0, 1'b0, 1'b1);
    repeat (2) tick(1'b1, 1'b0);
    send_slot(1'b0, 16'h1357, 16, 1'b0, 1'b0);
    send_slot(1'b1, 16'h2468, 7, 1'b0, 1'b0);
    chk("mid_pre_nxfer", xq.size(), 32'd1);
    chk_xq("mid_pre_x0", 0, 1'b1, 16'h1357);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, o_valid}, 32'd0);
    xq.delete();
    fe_cnt = 0;
    repeat (2) tick(1'b1, 1'b1);
    reset = 1'b0;
    repeat (7) tick(1'b1, 1'b1);
    send_slot(1'b0, 16'h9ABC, 16, 1'b0, 1'b0);
    repeat (2) tick(1'b0, 1'b0);
    chk("mid_nxfer", xq.size(), 32'd1);
    chk_xq("mid_x0", 0, 1'b1, 16'h9ABC);
    chk("mid_ferr", fe_cnt, 32'd0);

    // Inverted word clock polarity
    do_reset(1'b0, 1'b1, 1'b0);
    repeat (2) tick(1'b0, 1'b0);
    send_slot(1'b1, 16'h7FFF, 16, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("pol_left", {31'd0, o_is_left}, 32'd1);
    chk("pol_audio", {16'd0, o_audio}, 32'h00007FFF);
    repeat (2) tick(1'b1, 1'b0);
    chk("pol_nxfer", xq.size(), 32'd1);
    chk_xq("pol_x0", 0, 1'b1, 16'h7FFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
